univ_shreg: RTL
===============

# univ_shreg

Parametrised multi-channel universal shift register: the next-generation register part in the struct74 library after the dual D flip-flop. Each of CHANNELS independent lanes holds a WIDTH-bit register with hold, shift-up, shift-down and parallel-load modes, plus synchronous preset and clear. It serves the tinycpu datapath as the accumulator, shifter and general staging register. Unlike the dual DFF, it is fully synchronous, and preset and clear are sampled on the clock edge.

## Interface
- WIDTH, 4, bits per channel (≥2)
- CHANNELS, 2, number of independent channels (≥1)

- clk  in  1  rising-edge clock, shared by all channels
- rst  in  1  synchronous reset, active-high; clears every channel
- preset_n  in  CHANNELS  per-channel synchronous preset, active-low
- clear_n  in  CHANNELS  per-channel synchronous clear, active-low
- mode  in  2*CHANNELS  per-channel mode; channel c uses mode[2c+1:2c]
- su_in  in  CHANNELS  serial input for shift-up (enters bit 0)
- sd_in  in  CHANNELS  serial input for shift-down (enters bit WIDTH-1)
- d  in  WIDTH*CHANNELS  parallel load data; channel c uses d[c*WIDTH +: WIDTH]
- q  out  WIDTH*CHANNELS  register contents, same slicing as d
- qn  out  WIDTH*CHANNELS  bitwise complement of q
- su_out  out  CHANNELS  q bit WIDTH-1 of each channel, used for cascading shift-up
- sd_out  out  CHANNELS  q bit 0 of each channel, used for cascading shift-down

## Operation
- Each channel updates once per rising clk edge. Per-channel priority, highest first:
  1. rst=1: q=0.
  2. preset_n[c]=0: q=all ones.
  3. clear_n[c]=0: q=0.
  4. mode.
- Preset takes priority over clear, matching the 7474 convention.
- Modes (constants defined in the package):
  - 2'b00 HOLD: q unchanged.
  - 2'b01 SHUP: q[0]<=su_in, q[i]<=q[i-1] for i=1..WIDTH-1. Old q[WIDTH-1] is discarded.
  - 2'b10 SHDN: q[WIDTH-1]<=sd_in, q[i]<=q[i+1] for i=0..WIDTH-2. Old q[0] is discarded.
  - 2'b11 LOAD: q<=d slice.
- Channels are fully independent; no state is shared between them.
- Cascading is done externally: wire su_out[c] to su_in[c+1], or sd_out[c+1] to sd_in[c]. Because the serial outputs are registered, a cascade shifts one bit per clock with no combinational loop.
- All outputs are purely registered or derived from registers; there is no input-to-output combinational path.
- Serial in/out and mode are plain per-edge samples; there is no handshake.

## Timing
- Latency is 1 cycle. Any input sampled at edge N is visible on q, qn, su_out and sd_out after edge N.
- Reset values: q=0, qn=all ones, su_out=0, sd_out=0, for every channel.
- Asserting rst mid-shift aborts the shift at that edge. The first mode operation after rst deasserts acts on q=0.
- Simultaneous preset_n=0 and clear_n=0: result is all ones.
- Simultaneous preset or clear with a mode: preset/clear wins, and the mode is ignored for that cycle.
- Preset or clear on one channel has no effect on other channels in the same cycle.
- WIDTH=2 must work. The shift chains degenerate to a single internal move.
- Inputs must be stable within setup/hold of clk. There is no asynchronous path.

## Structure
- Package struct74_pkg holds:
  - Mode constants MODE_HOLD, MODE_SHUP, MODE_SHDN, MODE_LOAD.
  - A 2-bit mode typedef shreg_mode_t.
- Sub-module univ_shreg_chan: one WIDTH-bit channel with scalar controls.
- Top level: a generate loop instantiates CHANNELS copies and slices the flattened buses.
- qn, su_out and sd_out are continuous assigns off q inside the channel.

## Test plan
(WIDTH=4, CHANNELS=2 unless noted)
- Reset: rst=1 for 1 cycle with arbitrary inputs -> q=8'h00, qn=8'hFF, su_out=2'b00, sd_out=2'b00.
- Load then hold: ch0 LOAD d=4'hA, then HOLD for 3 cycles -> ch0 q=4'hA throughout, qn=4'h5. ch1 is untouched at 0.
- Shift-up: ch0 starting at 4'h1, SHUP with su_in=1 for 4 cycles -> q = 4'h3, 4'h7, 4'hF, 4'hF. su_out reads 1 from cycle 3 onward.
- Shift-down: ch1 starting at 4'h8, SHDN with sd_in=0 for 4 cycles -> q = 4'h4, 4'h2, 4'h1, 4'h0. sd_out=1 after cycle 3 only.
- Priority: preset_n=0 and clear_n=0 with mode=LOAD, d=4'h3 on ch0 -> ch0 q=4'hF. The next cycle with clear_n=0 alone gives q=4'h0. rst=1 together with preset_n=0 gives q=0.
- Cascade: su_out[0] wired to su_in[1], ch0=4'h8, ch1=4'h0, both SHUP with su_in[0]=0 -> after one edge ch1 q=4'h1 and ch0 q=4'h0.

Source files
------------

// File: rtl/struct74_pkg.sv
// Shared constants and types for the struct74 register parts.
// The mode encoding is common to every univ_shreg channel.
package struct74_pkg;

  typedef logic [1:0] shreg_mode_t;

  localparam shreg_mode_t MODE_HOLD = 2'b00;
  localparam shreg_mode_t MODE_SHUP = 2'b01;
  localparam shreg_mode_t MODE_SHDN = 2'b10;
  localparam shreg_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/univ_shreg_chan.sv
// One WIDTH-bit universal shift register lane with synchronous preset/clear.
// Preset beats clear, and both beat the selected mode.
module univ_shreg_chan
  import struct74_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             preset_n,
  input  logic             clear_n,
  input  shreg_mode_t      mode,
  input  logic             su_in,
  input  logic             sd_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             su_out,
  output logic             sd_out
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!preset_n) begin
      q <= '1;
    end else if (!clear_n) begin
      q <= '0;
    end else begin
      case (mode)
        MODE_SHUP: q <= {q[WIDTH-2:0], su_in};
        MODE_SHDN: q <= {sd_in, q[WIDTH-1:1]};
        MODE_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

  // Serial outputs come straight off the register so cascades never form a loop.
  assign qn     = ~q;
  assign su_out = q[WIDTH-1];
  assign sd_out = q[0];

endmodule

// File: rtl/univ_shreg.sv
// Multi-channel universal shift register; each lane is an independent
// univ_shreg_chan fed from slices of the flattened buses.
module univ_shreg
  import struct74_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       preset_n,
  input  logic [CHANNELS-1:0]       clear_n,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       su_in,
  input  logic [CHANNELS-1:0]       sd_in,
  input  logic [WIDTH*CHANNELS-1:0] d,
  output logic [WIDTH*CHANNELS-1:0] q,
  output logic [WIDTH*CHANNELS-1:0] qn,
  output logic [CHANNELS-1:0]       su_out,
  output logic [CHANNELS-1:0]       sd_out
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    univ_shreg_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .preset_n (preset_n[c]),
      .clear_n  (clear_n[c]),
      .mode     (shreg_mode_t'(mode[2*c +: 2])),
      .su_in    (su_in[c]),
      .sd_in    (sd_in[c]),
      .d        (d[c*WIDTH +: WIDTH]),
      .q        (q[c*WIDTH +: WIDTH]),
      .qn       (qn[c*WIDTH +: WIDTH]),
      .su_out   (su_out[c]),
      .sd_out   (sd_out[c])
    );
  end

endmodule
